// File: rtl/mmu_sequencer.sv
// Job sequencer for the systolic array: loads a weight tile, streams data rows and
// issues output writes delayed by the array pipeline latency.
module mmu_sequencer #(
    parameter int unsigned WIDTH_HEIGHT = 16,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned PIPE_LAT     = 33
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr_weight,
    input  logic [ADDR_WIDTH-1:0] base_addr_data,
    input  logic [ADDR_WIDTH-1:0] base_addr_output,
    input  logic [ADDR_WIDTH-1:0] num_rows,
    output logic                  busy,
    output logic                  done,
    output logic                  weight_rd_en,
    output logic [ADDR_WIDTH-1:0] weight_rd_addr,
    output logic                  weight_shift_en,
    output logic                  weight_latch,
    output logic                  data_rd_en,
    output logic [ADDR_WIDTH-1:0] data_rd_addr,
    output logic                  out_wr_en,
    output logic [ADDR_WIDTH-1:0] out_wr_addr
);

    typedef enum logic [2:0] {StIdle, StLoadW, StLatch, StStream, StDrain, StFin} state_e;

    localparam logic [ADDR_WIDTH-1:0] WLast = ADDR_WIDTH'(WIDTH_HEIGHT - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_WIDTH-1:0] num_rows_q, num_rows_d;
    logic [ADDR_WIDTH-1:0] base_data_q, base_data_d;
    logic [ADDR_WIDTH-1:0] weight_rd_addr_q, weight_rd_addr_d;
    logic [ADDR_WIDTH-1:0] data_rd_addr_q, data_rd_addr_d;
    logic [ADDR_WIDTH-1:0] out_wr_addr_q, out_wr_addr_d;
    logic [PIPE_LAT-1:0]   pipe_q, pipe_d;
    logic                  weight_shift_en_q, weight_shift_en_d;
    logic                  weight_latch_q, weight_latch_d;
    logic [ADDR_WIDTH-1:0] rows_last;

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        wr_cnt_d          = wr_cnt_q;
        num_rows_d        = num_rows_q;
        base_data_d       = base_data_q;
        weight_rd_addr_d  = weight_rd_addr_q;
        data_rd_addr_d    = data_rd_addr_q;
        out_wr_addr_d     = out_wr_addr_q;

        weight_rd_en      = (state_q == StLoadW);
        data_rd_en        = (state_q == StStream);
        done              = (state_q == StFin);
        busy              = (state_q != StIdle) && (state_q != StFin);
        out_wr_en         = pipe_q[PIPE_LAT-1];
        rows_last         = num_rows_q - 1'b1;

        pipe_d            = (pipe_q << 1) | PIPE_LAT'(data_rd_en);
        weight_shift_en_d = weight_rd_en;
        weight_latch_d    = (state_q == StLatch);

        // Final write holds its address so it stays stable once the enable drops.
        if (out_wr_en && (wr_cnt_q != rows_last)) begin
            wr_cnt_d      = wr_cnt_q + 1'b1;
            out_wr_addr_d = out_wr_addr_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d          = StLoadW;
                    cnt_d            = '0;
                    wr_cnt_d         = '0;
                    num_rows_d       = num_rows;
                    base_data_d      = base_addr_data;
                    weight_rd_addr_d = base_addr_weight + WLast;
                    out_wr_addr_d    = base_addr_output;
                end
            end
            StLoadW: begin
                if (cnt_q == WLast) begin
                    state_d = StLatch;
                    cnt_d   = '0;
                end else begin
                    cnt_d            = cnt_q + 1'b1;
                    weight_rd_addr_d = weight_rd_addr_q - 1'b1;
                end
            end
            StLatch: begin
                if (num_rows_q == '0) begin
                    state_d = StFin;
                end else begin
                    state_d        = StStream;
                    cnt_d          = '0;
                    data_rd_addr_d = base_data_q;
                end
            end
            StStream: begin
                if (cnt_q == rows_last) begin
                    state_d = StDrain;
                end else begin
                    cnt_d          = cnt_q + 1'b1;
                    data_rd_addr_d = data_rd_addr_q + 1'b1;
                end
            end
            StDrain: begin
                if (out_wr_en && (wr_cnt_q == rows_last)) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign weight_rd_addr  = weight_rd_addr_q;
    assign data_rd_addr    = data_rd_addr_q;
    assign out_wr_addr     = out_wr_addr_q;
    assign weight_shift_en = weight_shift_en_q;
    assign weight_latch    = weight_latch_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= StIdle;
            cnt_q             <= '0;
            wr_cnt_q          <= '0;
            num_rows_q        <= '0;
            base_data_q       <= '0;
            weight_rd_addr_q  <= '0;
            data_rd_addr_q    <= '0;
            out_wr_addr_q     <= '0;
            pipe_q            <= '0;
            weight_shift_en_q <= 1'b0;
            weight_latch_q    <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            wr_cnt_q          <= wr_cnt_d;
            num_rows_q        <= num_rows_d;
            base_data_q       <= base_data_d;
            weight_rd_addr_q  <= weight_rd_addr_d;
            data_rd_addr_q    <= data_rd_addr_d;
            out_wr_addr_q     <= out_wr_addr_d;
            pipe_q            <= pipe_d;
            weight_shift_en_q <= weight_shift_en_d;
            weight_latch_q    <= weight_latch_d;
        end
    end

endmodule
